// File: rtl/hack_pkg.sv
// Shared Hack memory types and widths.
// Imported by RAM8 and every larger RAM tile built from it.
package hack_pkg;
   localparam int WORD_W      = 16;
   localparam int RAM8_ADDR_W = 3;
   typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/ram8_dmux8way.sv
// 1-to-2 demux cell and the 8-way demux tree built from it.
// Routes a single strobe to one of eight one-hot outputs.
module _demux (
   input  logic in_,
   input  logic sel,
   output logic a,
   output logic b
);
   assign a = in_ & ~sel;
   assign b = in_ & sel;
endmodule

module dmux8way (
   input  logic       in_,
   input  logic [2:0] sel,
   output logic       out0,
   output logic       out1,
   output logic       out2,
   output logic       out3,
   output logic       out4,
   output logic       out5,
   output logic       out6,
   output logic       out7
);
   logic lo, hi;
   logic l0, l1, h0, h1;

   // sel[2] splits halves, sel[1] quarters, sel[0] picks the word
   _demux u_root (.in_(in_), .sel(sel[2]), .a(lo), .b(hi));

   _demux u_lo (.in_(lo), .sel(sel[1]), .a(l0), .b(l1));
   _demux u_hi (.in_(hi), .sel(sel[1]), .a(h0), .b(h1));

   _demux u_q0 (.in_(l0), .sel(sel[0]), .a(out0), .b(out1));
   _demux u_q1 (.in_(l1), .sel(sel[0]), .a(out2), .b(out3));
   _demux u_q2 (.in_(h0), .sel(sel[0]), .a(out4), .b(out5));
   _demux u_q3 (.in_(h1), .sel(sel[0]), .a(out6), .b(out7));
endmodule

// File: rtl/ram8.sv
// Eight-word register file: demuxed write strobe,
// combinational read of the addressed word.
module ram8
   import hack_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       in_,
   input  logic                   load,
   input  logic [RAM8_ADDR_W-1:0] address,
   output logic [WIDTH-1:0]       out
);
   logic [7:0]       ld;
   logic [WIDTH-1:0] mem [DEPTH];

   dmux8way u_dmux (
      .in_  (load),
      .sel  (address),
      .out0 (ld[0]),
      .out1 (ld[1]),
      .out2 (ld[2]),
      .out3 (ld[3]),
      .out4 (ld[4]),
      .out5 (ld[5]),
      .out6 (ld[6]),
      .out7 (ld[7])
   );

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mem[i] <= '0;
         end else if (ld[i]) begin
            mem[i] <= in_;
         end
      end
   end

   assign out = mem[address];
endmodule

// File: tb/tb_ram8.sv
// Randomized and directed bench for ram8 against an array model.
module tb_ram8;
   logic        clk;
   logic        rst_n;
   logic [15:0] in_;
   logic        load;
   logic [2:0]  address;
   logic [15:0] dout;

   logic [15:0] model [8];
   int checks;
   int failures;
   bit cmp_en;

   ram8 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_     (in_),
      .load    (load),
      .address (address),
      .out     (dout)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) model[i] <= 16'h0;
      end else if (load) begin
         model[address] <= in_;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         checks++;
         if (dout !== model[address]) begin
            failures++;
            $display("FAIL cycle_cmp addr=%0d got=%h exp=%h",
                     address, dout, model[address]);
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] exp);
      checks++;
      if (dout !== exp) begin
         failures++;
         $display("FAIL %s addr=%0d got=%h exp=%h",
                  name, address, dout, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      cmp_en = 1'b0;
      rst_n = 1'b1;
      load = 1'b0;
      in_ = 16'h0;
      address = 3'd0;
      #1 rst_n = 1'b0;
      load = 1'b1;
      in_ = 16'hFFFF;
      #1 cmp_en = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1 chk("reset_zero", 16'h0);
      end

      // single write
      load = 1'b0;
      rst_n = 1'b1;
      step();
      address = 3'd3;
      in_ = 16'h1234;
      load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1 chk("single_write", (i == 3) ? 16'h1234 : 16'h0);
      end

      // fill and readback
      step();
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         in_ = 16'hA000 + 16'(i);
         load = 1'b1;
         step();
      end
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1 chk("fill_read", 16'hA000 + 16'(i));
      end

      // hold with load low
      address = 3'd5;
      in_ = 16'hDEAD;
      repeat (3) step();
      chk("hold", 16'hA005);
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1 chk("hold_all", 16'hA000 + 16'(i));
      end

      // read during write
      step();
      address = 3'd2;
      in_ = 16'h0BEE;
      load = 1'b1;
      #1 chk("rdw_before", 16'hA002);
      step();
      load = 1'b0;
      chk("rdw_after", 16'h0BEE);
      address = 3'd6;
      #1 chk("rdw_other", 16'hA006);

      // reset between edges
      step();
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1 chk("mid_reset", 16'h0);
      end
      rst_n = 1'b1;
      address = 3'd7;
      in_ = 16'h7777;
      load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1 chk("post_reset", (i == 7) ? 16'h7777 : 16'h0);
      end

      // randomized traffic with occasional mid-cycle resets
      for (int n = 0; n < 400; n++) begin
         step();
         address = 3'($urandom_range(0, 7));
         in_ = 16'($urandom);
         load = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 49) == 0) begin
            rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         #2;
         checks++;
         if (dout !== model[address]) begin
            failures++;
            $display("FAIL rand_mid addr=%0d got=%h exp=%h",
                     address, dout, model[address]);
         end
      end

      step();
      load = 1'b0;
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
